k_alu_6: RTL and testbench

K_ALU_6 -- requirements
Module: k_alu_6

---
 rtl/k_alu_6.sv | 81 ++++++++
 tb/tb_k_alu_6.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/k_alu_6.sv
// Six-bit ALU with a single registered result. The command word carries the
// function code and both operands; the result appears one clock later.
module k_alu_6 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] command,
  output logic [5:0]  RES
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_AND  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_NOT  = 4'b0101,
    OP_SLL  = 4'b0110,
    OP_SRL  = 4'b0111,
    OP_SRA  = 4'b1000,
    OP_INC  = 4'b1001,
    OP_DEC  = 4'b1010,
    OP_SLT  = 4'b1011,
    OP_SGT  = 4'b1100,
    OP_NOR  = 4'b1101,
    OP_HAM  = 4'b1110,
    OP_MOVB = 4'b1111
  } func_t;

  func_t       func;
  logic [5:0]  a;
  logic [5:0]  b;
  logic [5:0]  res_next;
  logic [2:0]  ham;
  logic [5:0]  sra_res;

  assign func = func_t'(command[31:28]);
  assign a    = command[13:8];
  assign b    = command[5:0];

  // Shifting by the full 6-bit B naturally flushes to zero (or sign) at B>=6.
  assign sra_res = $unsigned($signed(a) >>> b);

  always_comb begin
    ham = 3'd0;
    for (int i = 0; i < 6; i++) begin
      ham = ham + {2'b00, a[i]};
    end
  end

  always_comb begin
    res_next = 6'd0;
    unique case (func)
      OP_ADD:  res_next = a + b;
      OP_SUB:  res_next = a - b;
      OP_AND:  res_next = a & b;
      OP_OR:   res_next = a | b;
      OP_XOR:  res_next = a ^ b;
      OP_NOT:  res_next = ~a;
      OP_SLL:  res_next = a << b;
      OP_SRL:  res_next = a >> b;
      OP_SRA:  res_next = sra_res;
      OP_INC:  res_next = a + 6'd1;
      OP_DEC:  res_next = a - 6'd1;
      OP_SLT:  res_next = {5'd0, ($signed(a) < $signed(b))};
      OP_SGT:  res_next = {5'd0, ($signed(a) > $signed(b))};
      OP_NOR:  res_next = ~(a | b);
      OP_HAM:  res_next = {3'd0, ham};
      OP_MOVB: res_next = b;
      default: res_next = 6'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      RES <= 6'd0;
    end else begin
      RES <= res_next;
    end
  end

endmodule

// File: tb/tb_k_alu_6.sv
// Directed self-checking bench for k_alu_6: reset behaviour, a full function
// sweep, shift bounds, wrap-around, signed compares and ignored command bits.
module tb_k_alu_6;

  logic        clk;
  logic        rst_n;
  logic [31:0] command;
  logic [5:0]  RES;

  int compared;
  int mismatched;

  k_alu_6 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .command (command),
    .RES     (RES)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [3:0] f, input logic [5:0] a,
                                     input logic [5:0] b);
    return {f, 14'd0, a, 2'b00, b};
  endfunction

  // Drive one command, let it be captured, then sample 1 time unit later.
  task automatic applyStimulus(input logic [31:0] cmd, input logic rstn);
    command = cmd;
    rst_n   = rstn;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [5:0] expected);
    compared++;
    assert (RES === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: RES=%b expected=%b", tag, RES, expected);
    end
  endtask

  logic [5:0] sweep_exp [16];
  logic [31:0] base;
  logic [31:0] noisy;

  initial begin
    compared   = 0;
    mismatched = 0;
    sweep_exp = '{6'b111111, 6'b111011, 6'b000000, 6'b111111,
                  6'b111111, 6'b000010, 6'b110100, 6'b001111,
                  6'b111111, 6'b111110, 6'b111100, 6'b000001,
                  6'b000000, 6'b000000, 6'b000101, 6'b000010};
    command = '1;
    rst_n   = 1'b0;

    // Reset held for two edges with an all-ones command.
    applyStimulus('1, 1'b0);
    checkOutput("reset_edge1", 6'b000000);
    applyStimulus('1, 1'b0);
    checkOutput("reset_edge2", 6'b000000);
    rst_n = 1'b1;
    #1;
    checkOutput("release_no_edge", 6'b000000);
    applyStimulus('1, 1'b1);
    checkOutput("first_after_release", 6'b111111);

    // Full function sweep on A=111101, B=000010.
    for (int f = 0; f < 16; f++) begin
      applyStimulus(mk(4'(f), 6'b111101, 6'b000010), 1'b1);
      checkOutput($sformatf("sweep_func%0d", f), sweep_exp[f]);
    end

    // Shift bounds with A=100001.
    applyStimulus(mk(4'b0110, 6'b100001, 6'd0), 1'b1);
    checkOutput("sll_b0", 6'b100001);
    applyStimulus(mk(4'b0111, 6'b100001, 6'd0), 1'b1);
    checkOutput("srl_b0", 6'b100001);
    applyStimulus(mk(4'b1000, 6'b100001, 6'd0), 1'b1);
    checkOutput("sra_b0", 6'b100001);
    applyStimulus(mk(4'b0110, 6'b100001, 6'd6), 1'b1);
    checkOutput("sll_b6", 6'b000000);
    applyStimulus(mk(4'b0111, 6'b100001, 6'd6), 1'b1);
    checkOutput("srl_b6", 6'b000000);
    applyStimulus(mk(4'b1000, 6'b100001, 6'd6), 1'b1);
    checkOutput("sra_b6", 6'b111111);
    applyStimulus(mk(4'b1000, 6'b100001, 6'd5), 1'b1);
    checkOutput("sra_b5", 6'b111111);
    applyStimulus(mk(4'b0110, 6'b000011, 6'd63), 1'b1);
    checkOutput("sll_b63", 6'b000000);
    applyStimulus(mk(4'b1000, 6'b011111, 6'd63), 1'b1);
    checkOutput("sra_pos_b63", 6'b000000);
    applyStimulus(mk(4'b0111, 6'b100000, 6'd5), 1'b1);
    checkOutput("srl_b5", 6'b000001);

    // Wrap-around and signed compares.
    applyStimulus(mk(4'b1001, 6'b111111, 6'd0), 1'b1);
    checkOutput("inc_wrap", 6'b000000);
    applyStimulus(mk(4'b1010, 6'b000000, 6'd0), 1'b1);
    checkOutput("dec_wrap", 6'b111111);
    applyStimulus(mk(4'b0000, 6'b111111, 6'b000001), 1'b1);
    checkOutput("add_wrap", 6'b000000);
    applyStimulus(mk(4'b1011, 6'b011111, 6'b100000), 1'b1);
    checkOutput("slt_31_vs_m32", 6'b000000);
    applyStimulus(mk(4'b1100, 6'b011111, 6'b100000), 1'b1);
    checkOutput("sgt_31_vs_m32", 6'b000001);
    applyStimulus(mk(4'b1011, 6'b010101, 6'b010101), 1'b1);
    checkOutput("slt_equal", 6'b000000);
    applyStimulus(mk(4'b1100, 6'b010101, 6'b010101), 1'b1);
    checkOutput("sgt_equal", 6'b000000);
    applyStimulus(mk(4'b1011, 6'b100000, 6'b011111), 1'b1);
    checkOutput("slt_m32_vs_31", 6'b000001);

    // Ignored command bits must not disturb the result.
    base = mk(4'b0001, 6'b101010, 6'b000111);
    for (int i = 0; i < 4; i++) begin
      noisy = base;
      noisy[27:14] = 14'($urandom);
      noisy[7:6]   = 2'($urandom);
      applyStimulus(noisy, 1'b1);
      checkOutput($sformatf("ignored_bits%0d", i), 6'b100011);
    end
    applyStimulus(mk(4'b1110, 6'b111111, 6'd0), 1'b1);
    checkOutput("ham_all_ones", 6'b000110);
    applyStimulus(mk(4'b1110, 6'b000000, 6'd0), 1'b1);
    checkOutput("ham_zero", 6'b000000);

    // Mid-stream reset discards the pending result.
    applyStimulus(mk(4'b0000, 6'd1, 6'd1), 1'b1);
    checkOutput("pre_reset_add", 6'b000010);
    applyStimulus(mk(4'b1001, 6'd20, 6'd0), 1'b0);
    checkOutput("midstream_reset", 6'b000000);
    applyStimulus(mk(4'b1111, 6'd0, 6'd5), 1'b1);
    checkOutput("post_reset_movb", 6'b000101);

    // A reset pulse between edges has no effect.
    command = mk(4'b1111, 6'd0, 6'd7);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    checkOutput("glitch_hold", 6'b000101);
    @(posedge clk);
    #1;
    checkOutput("glitch_ignored", 6'b000111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
